// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI bit/frame counter.
package spi_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // A zero or oversized request falls back to the longest frame the counter supports.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      if ((len == 0) || (len > max_len)) begin
         return max_len;
      end
      return len;
   endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// SPI bit/frame counter: counts enabled bit strobes 1..len per frame, with continuous mode and abort.
// Optional completed-frame counter (frame_cnt) when SPI_BITCNT_FRAMECNT_EN is defined.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; count held at 0
// RUN   | counting enabled strobes up to len_q; wraps or returns to IDLE
module spi_bit_counter
   import spi_pkg::*;
#(
   parameter int FRAME_MAX = 16,
   parameter int CNT_W     = $clog2(FRAME_MAX + 1)
`ifdef SPI_BITCNT_FRAMECNT_EN
   , parameter int FCNT_W  = 8
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] frame_len,
   input  logic             cont,
   input  logic             enable,
   input  logic             abort,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             last_bit,
   output logic             frame_done
`ifdef SPI_BITCNT_FRAMECNT_EN
   , output logic [FCNT_W-1:0] frame_cnt
`endif
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] len_q;
   logic             done_q;
   logic             start_ok;
   logic             wrap;

   assign start_ok = (state == IDLE) && start && !abort;
   assign wrap     = (state == RUN) && enable && (count == len_q) && !abort;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (wrap && !cont) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // On a wrap in continuous mode the completing strobe already counts as bit 1 of the next frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (abort || start_ok) begin
         count <= '0;
      end else if ((state == RUN) && enable) begin
         if (count == len_q) begin
            count <= cont ? CNT_W'(1) : '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_q <= CNT_W'(FRAME_MAX);
      end else if (start_ok) begin
         len_q <= CNT_W'(clamp_len(32'(frame_len), FRAME_MAX));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= wrap;
      end
   end

`ifdef SPI_BITCNT_FRAMECNT_EN
   // Survives abort; only reset clears the completed-frame tally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt <= '0;
      end else if (wrap) begin
         frame_cnt <= frame_cnt + FCNT_W'(1);
      end
   end
`endif

   assign busy       = (state == RUN);
   assign last_bit   = (state == RUN) && (count == len_q);
   assign frame_done = done_q;

endmodule

// File: tb/tb_spi_bit_counter.sv
// Self-checking bench for spi_bit_counter: directed scenarios plus randomized traffic
// compared cycle by cycle against a frame-level reference model.
module tb_spi_bit_counter;

   localparam int FRAME_MAX = 16;
   localparam int CNT_W     = $clog2(FRAME_MAX + 1);
`ifdef SPI_BITCNT_FRAMECNT_EN
   localparam int FCNT_W    = 2;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] frame_len = '0;
   logic             cont = 1'b0;
   logic             enable = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             last_bit;
   logic             frame_done;
`ifdef SPI_BITCNT_FRAMECNT_EN
   logic [FCNT_W-1:0] frame_cnt;
`endif

   spi_bit_counter #(
      .FRAME_MAX (FRAME_MAX)
`ifdef SPI_BITCNT_FRAMECNT_EN
      , .FCNT_W  (FCNT_W)
`endif
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .frame_len  (frame_len),
      .cont       (cont),
      .enable     (enable),
      .abort      (abort),
      .count      (count),
      .busy       (busy),
      .last_bit   (last_bit),
      .frame_done (frame_done)
`ifdef SPI_BITCNT_FRAMECNT_EN
      , .frame_cnt (frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: frame in progress, bits received so far, frame length, completion
   bit m_active;
   int m_bits;
   int m_len;
   bit m_done;
   int m_frames;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_active = 0;
      m_bits   = 0;
      m_len    = FRAME_MAX;
      m_done   = 0;
      m_frames = 0;
   endtask

   task automatic m_update(input bit s, input int fl, input bit c, input bit e, input bit a);
      m_done = 0;
      if (a) begin
         m_active = 0;
         m_bits   = 0;
      end else if (!m_active) begin
         if (s) begin
            m_active = 1;
            m_bits   = 0;
            m_len    = ((fl == 0) || (fl > FRAME_MAX)) ? FRAME_MAX : fl;
         end
      end else if (e) begin
         if (m_bits == m_len) begin
            m_done = 1;
            m_frames++;
            if (c) begin
               m_bits = 1;
            end else begin
               m_active = 0;
               m_bits   = 0;
            end
         end else begin
            m_bits++;
         end
      end
   endtask

   task automatic check_all();
      chk("count", int'(count), m_bits);
      chk("busy", int'(busy), int'(m_active));
      chk("last_bit", int'(last_bit), int'(m_active && (m_bits == m_len)));
      chk("frame_done", int'(frame_done), int'(m_done));
`ifdef SPI_BITCNT_FRAMECNT_EN
      chk("frame_cnt", int'(frame_cnt), m_frames % (1 << FCNT_W));
`endif
   endtask

   task automatic step(input bit s, input int fl, input bit c, input bit e, input bit a);
      int flt;
      start     = s;
      frame_len = fl[CNT_W-1:0];
      cont      = c;
      enable    = e;
      abort     = a;
      flt       = int'(frame_len);
      @(posedge clk);
      m_update(s, flt, c, e, a);
      #1;
      check_all();
   endtask

   int pulses;
   int flv[2];

   initial begin
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      reset = 1'b1;

      // start with enable in the same cycle: enable dropped, count stays 0
      step(1, 8, 0, 1, 0);
      chk("start_en_count", int'(count), 0);
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 0, 1, 0);
         chk("len8_count", int'(count), i);
      end
      chk("len8_last_bit", int'(last_bit), 1);
      step(0, 0, 0, 1, 0);
      chk("len8_done", int'(frame_done), 1);
      chk("len8_idle", int'(busy), 0);
      step(0, 0, 0, 0, 0);

      // continuous frames of 4
      pulses = 0;
      step(1, 4, 1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 1, 0);
         chk("cont_count", int'(count), (i % 4) + 1);
         if (frame_done) pulses++;
      end
      chk("cont_pulses", pulses, 2);
      step(0, 0, 0, 0, 1);

      // clamp of zero and oversized lengths
      flv[0] = 0;
      flv[1] = 20;
      for (int k = 0; k < 2; k++) begin
         step(1, flv[k], 0, 0, 0);
         for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 1, 0);
            chk("clamp_last_bit", int'(last_bit), (i == 16) ? 1 : 0);
         end
         step(0, 0, 0, 1, 0);
         chk("clamp_done", int'(frame_done), 1);
      end

      // abort together with enable at count 3
      step(1, 8, 0, 0, 0);
      repeat (3) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      chk("abort_count", int'(count), 0);
      chk("abort_done", int'(frame_done), 0);
      chk("abort_busy", int'(busy), 0);

      // asynchronous reset mid-frame at count 5
      step(1, 10, 0, 0, 0);
      repeat (5) step(0, 0, 0, 1, 0);
      reset = 1'b0;
      #1;
      m_reset();
      chk("rst_count", int'(count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(frame_done), 0);
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b1;

      // randomized traffic, including RUN-time starts and the occasional abort
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
              int'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
